// File: rtl/sparse_term_scheduler.sv
// -----------------------------------------------------------------------------
// sparse_term_scheduler
//
// Purpose:
//   Steps the polymult controller through every sparse-operand word of one
//   multiplication. For each job it issues a one-cycle start to the
//   controller at sparse address base+index. It waits for the controller to
//   acknowledge by raising busy. It then waits for busy to fall, and after
//   the last job it pulses done. When DUMMY_PAD_EN is defined, the run is
//   padded with dummy jobs so every multiplication takes exactly MAX_TERMS
//   jobs (constant time). Dummy jobs use the full real-job handshake.
//
// Configuration macro:
//   DUMMY_PAD_EN  - when defined, the job total is MAX_TERMS and the jobs
//                   from n_eff onward are dummy jobs. When undefined, the job
//                   total is n_eff and ctrl_dummy is constant 0.
//
// Ports:
//   clk               in   clock
//   rst_n             in   asynchronous active-low reset
//   start             in   1-cycle request, sampled only in IDLE
//   num_terms         in   number of real sparse words (clamped to MAX_TERMS)
//   base_addr         in   sparse address of term 0
//   ctrl_start        out  1-cycle pulse to controller start_process
//   ctrl_sparse_addr  out  sparse address for the job, valid with ctrl_start
//   ctrl_dummy        out  high for the whole of a dummy job
//   ctrl_busy         in   controller busy
//   busy              out  high from accepted start until done
//   done              out  1-cycle pulse when all jobs have finished
//   term_idx          out  index of the current job (real and dummy)
//   err               out  sticky ack-timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module sparse_term_scheduler #(
  parameter int ADDR_W    = 10,
  parameter int MAX_TERMS = 50,
  parameter int CNT_W     = 6,
  parameter int ACK_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ctrl_start,
  output logic [ADDR_W-1:0] ctrl_sparse_addr,
  output logic              ctrl_dummy,
  input  logic              ctrl_busy,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  term_idx,
  output logic              err
);

  localparam int ACK_CNT_W = $clog2(ACK_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  // Saturate the requested term count to the sparse memory depth.
  function automatic logic [CNT_W-1:0] f_clamp_terms(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : n;
  endfunction

  // Number of jobs for a run with n_eff real words.
  function automatic logic [CNT_W-1:0] f_job_total(input logic [CNT_W-1:0] n_eff);
`ifdef DUMMY_PAD_EN
    f_job_total = CNT_W'(MAX_TERMS);
`else
    f_job_total = n_eff;
`endif
  endfunction

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_n_eff, w_n_eff_nxt;
  logic [ADDR_W-1:0]    r_base, w_base_nxt;
  logic [CNT_W-1:0]     r_term_idx, w_term_idx_nxt;
  logic [ACK_CNT_W-1:0] r_ack_cnt, w_ack_cnt_nxt;
  logic                 r_ctrl_busy_d;
  logic                 r_ctrl_start, w_ctrl_start_nxt;
  logic [ADDR_W-1:0]    r_ctrl_addr, w_ctrl_addr_nxt;
  logic                 r_ctrl_dummy, w_ctrl_dummy_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;

  logic [CNT_W-1:0]     w_new_n_eff;
  logic [CNT_W-1:0]     w_total;
  logic                 w_is_dummy;
  logic                 w_busy_fall;

  assign w_new_n_eff = f_clamp_terms(num_terms);
  assign w_total     = f_job_total(r_n_eff);
  // Real jobs come first, so any index at or past n_eff is padding.
`ifdef DUMMY_PAD_EN
  assign w_is_dummy  = (r_term_idx >= r_n_eff);
`else
  assign w_is_dummy  = 1'b0;
`endif
  // The controller's process_done is sticky, so job completion is taken
  // from the falling edge of its busy line instead.
  assign w_busy_fall = r_ctrl_busy_d & ~ctrl_busy;

  always_comb begin
    w_state_nxt      = r_state;
    w_n_eff_nxt      = r_n_eff;
    w_base_nxt       = r_base;
    w_term_idx_nxt   = r_term_idx;
    w_ack_cnt_nxt    = r_ack_cnt;
    w_ctrl_start_nxt = 1'b0;
    w_ctrl_addr_nxt  = r_ctrl_addr;
    w_ctrl_dummy_nxt = r_ctrl_dummy;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_n_eff_nxt    = w_new_n_eff;
          w_base_nxt     = base_addr;
          w_busy_nxt     = 1'b1;
          w_term_idx_nxt = '0;
          w_err_nxt      = 1'b0;
          w_state_nxt    = (f_job_total(w_new_n_eff) == '0) ? S_FINISH : S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_ctrl_start_nxt = 1'b1;
        w_ctrl_addr_nxt  = w_is_dummy ? r_base : (r_base + ADDR_W'(r_term_idx));
        w_ctrl_dummy_nxt = w_is_dummy;
        w_ack_cnt_nxt    = '0;
        w_state_nxt      = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (ctrl_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_ack_cnt == ACK_CNT_W'(ACK_WAIT - 1)) begin
          // Controller never acknowledged: abandon the run but still
          // close it out with a done pulse.
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + ACK_CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (w_busy_fall) begin
          if ((r_term_idx + CNT_W'(1)) == w_total) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_term_idx_nxt = r_term_idx + CNT_W'(1);
            w_state_nxt    = S_ISSUE;
          end
        end
      end

      S_FINISH: begin
        w_done_nxt       = 1'b1;
        w_busy_nxt       = 1'b0;
        w_ctrl_dummy_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_n_eff       <= '0;
      r_base        <= '0;
      r_term_idx    <= '0;
      r_ack_cnt     <= '0;
      r_ctrl_busy_d <= 1'b0;
      r_ctrl_start  <= 1'b0;
      r_ctrl_addr   <= '0;
      r_ctrl_dummy  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_n_eff       <= w_n_eff_nxt;
      r_base        <= w_base_nxt;
      r_term_idx    <= w_term_idx_nxt;
      r_ack_cnt     <= w_ack_cnt_nxt;
      r_ctrl_busy_d <= ctrl_busy;
      r_ctrl_start  <= w_ctrl_start_nxt;
      r_ctrl_addr   <= w_ctrl_addr_nxt;
      r_ctrl_dummy  <= w_ctrl_dummy_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign ctrl_start       = r_ctrl_start;
  assign ctrl_sparse_addr = r_ctrl_addr;
  assign ctrl_dummy       = r_ctrl_dummy;
  assign busy             = r_busy;
  assign done             = r_done;
  assign term_idx         = r_term_idx;
  assign err              = r_err;

endmodule

// File: tb/tb_sparse_term_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sparse_term_scheduler
//
// Directed bench for sparse_term_scheduler. A small controller model raises
// busy for a fixed number of cycles after each ctrl_start, or never answers
// when no_ack is set. A negedge monitor records every job's address, dummy
// flag and index, plus the done pulses and their cycle numbers.
// The expected job counts follow DUMMY_PAD_EN.
// -----------------------------------------------------------------------------
module tb_sparse_term_scheduler;

  localparam int MAXT     = 50;
  localparam int BUSY_LEN = 5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] num_terms;
  logic [9:0] base_addr;
  logic       ctrl_start;
  logic [9:0] ctrl_sparse_addr;
  logic       ctrl_dummy;
  logic       ctrl_busy;
  logic       busy;
  logic       done;
  logic [5:0] term_idx;
  logic       err;

  sparse_term_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .num_terms        (num_terms),
    .base_addr        (base_addr),
    .ctrl_start       (ctrl_start),
    .ctrl_sparse_addr (ctrl_sparse_addr),
    .ctrl_dummy       (ctrl_dummy),
    .ctrl_busy        (ctrl_busy),
    .busy             (busy),
    .done             (done),
    .term_idx         (term_idx),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model
  logic no_ack = 1'b0;
  int   m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      m_cnt <= 0;
    else if (ctrl_start && !no_ack)  m_cnt <= BUSY_LEN;
    else if (m_cnt != 0)             m_cnt <= m_cnt - 1;
  end
  assign ctrl_busy = (m_cnt != 0);

  // Monitor
  int         n_pulse, n_done, first_cyc, done_cyc, t0;
  logic [9:0] rec_addr  [0:63];
  logic       rec_dummy [0:63];
  logic [5:0] rec_idx   [0:63];

  always @(negedge clk) begin
    if (ctrl_start) begin
      if (n_pulse < 64) begin
        rec_addr[n_pulse]  = ctrl_sparse_addr;
        rec_dummy[n_pulse] = ctrl_dummy;
        rec_idx[n_pulse]   = term_idx;
      end
      if (n_pulse == 0) first_cyc = cyc;
      n_pulse++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int n_eff_of(input int n);
    return (n > MAXT) ? MAXT : n;
  endfunction

  function automatic int exp_jobs(input int n);
`ifdef DUMMY_PAD_EN
    return MAXT;
`else
    return n_eff_of(n);
`endif
  endfunction

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_done == 0) check_eq("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic launch(input logic [5:0] n, input logic [9:0] b);
    @(negedge clk);
    n_pulse   = 0;
    n_done    = 0;
    first_cyc = -1;
    done_cyc  = -1;
    num_terms = n;
    base_addr = b;
    start     = 1'b1;
    t0        = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_job(input int n, input logic [9:0] b);
    int         ej, ne;
    logic [9:0] ea;
    logic       ed;
    ej = exp_jobs(n);
    ne = n_eff_of(n);
    check_eq("done_count", n_done, 1);
    check_eq("job_count", n_pulse, ej);
    check_eq("busy_after", busy, 0);
    check_eq("err_after", err, 0);
    if (ej > 0) begin
      check_eq("start_latency", first_cyc - t0, 2);
      check_eq("last_term_idx", term_idx, ej - 1);
    end
    for (int i = 0; i < ej && i < n_pulse && i < 64; i++) begin
      ea = (i < ne) ? (b + 10'(i)) : b;
`ifdef DUMMY_PAD_EN
      ed = (i >= ne);
`else
      ed = 1'b0;
`endif
      check_eq("job_addr", rec_addr[i], ea);
      check_eq("job_dummy", rec_dummy[i], ed);
      check_eq("job_idx", rec_idx[i], i);
    end
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    start     = 1'b0;
    num_terms = '0;
    base_addr = '0;
    n_pulse   = 0;
    n_done    = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ctrl_start", ctrl_start, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_term_idx", term_idx, 0);
    check_eq("rst_addr", ctrl_sparse_addr, 0);
    check_eq("rst_dummy", ctrl_dummy, 0);
    rst_n = 1'b1;

    // Three real terms
    launch(6'd3, 10'h010);
    check_eq("busy_during", busy, 1);
    wait_done(2000);
    check_job(3, 10'h010);

    // Padding case with two real terms (all real when padding is off)
    launch(6'd2, 10'h010);
    wait_done(2000);
    check_job(2, 10'h010);

    // Over-range count is clamped
    launch(6'd60, 10'h040);
    wait_done(2000);
    check_job(60, 10'h040);

    // Ack timeout
    no_ack = 1'b1;
    launch(6'd2, 10'h020);
    wait_done(200);
    check_eq("to_err", err, 1);
    check_eq("to_jobs", n_pulse, 1);
    check_eq("to_done_count", n_done, 1);
    check_eq("to_done_cyc", done_cyc - t0, 7);
    check_eq("to_busy", busy, 0);
    no_ack = 1'b0;
    launch(6'd1, 10'h000);
    check_eq("err_cleared", err, 0);
    check_eq("busy_restart", busy, 1);
    wait_done(2000);
    check_job(1, 10'h000);

    // Start while busy is ignored
    launch(6'd3, 10'h020);
    repeat (6) @(negedge clk);
    num_terms = 6'd10;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    check_job(3, 10'h020);

    // Reset in WAIT_DONE aborts without done
    launch(6'd3, 10'h030);
    k = 0;
    while (n_pulse < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("pulses_before_rst", (n_pulse >= 2), 1);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_ctrl_busy", ctrl_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", ctrl_sparse_addr, 0);
    check_eq("mid_rst_term_idx", term_idx, 0);
    check_eq("mid_rst_start", ctrl_start, 0);
    check_eq("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("no_done_after_rst", n_done, 0);
    check_eq("idle_after_rst", busy, 0);

    // Zero terms
    launch(6'd0, 10'h100);
    wait_done(2000);
    check_job(0, 10'h100);
`ifndef DUMMY_PAD_EN
    check_eq("zero_done_cyc", done_cyc - t0, 2);
`endif

    // Address wrap
    launch(6'd2, 10'h3FF);
    wait_done(2000);
    check_job(2, 10'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
